// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds the reset fetch address, the FSM state encoding and the PC-increment helper.
package fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;

    typedef enum logic [2:0] {
        ST_ISSUE = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DROP  = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    // Sequential PC step; wraps modulo 2^32 with no overflow flag.
    function automatic logic [XLEN-1:0] pc_add4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bundle: redirect input, instruction-memory handshake and the IF/ID slot.
// master = fetch unit side, slave = next-PC calculator / memory / decode side.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            im_req;
    logic [XLEN-1:0] im_addr;
    logic            im_rvalid;
    logic [XLEN-1:0] im_rdata;
    logic            id_stall;
    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_pc_add_4;
    logic            if_adel;

    modport master (
        input  redirect_valid, redirect_pc, im_rvalid, im_rdata, id_stall,
        output im_req, im_addr, if_valid, if_instr, if_pc, if_pc_add_4, if_adel
    );

    modport slave (
        output redirect_valid, redirect_pc, im_rvalid, im_rdata, id_stall,
        input  im_req, im_addr, if_valid, if_instr, if_pc, if_pc_add_4, if_adel
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: holds the PC, issues one-outstanding word fetches, and fills the
// IF/ID slot through a one-entry skid buffer; redirects flush, misaligned targets halt.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    state_e          r_state, w_next;
    logic [XLEN-1:0] r_pc;
    logic            r_im_req;
    logic [XLEN-1:0] r_im_addr;
    logic            r_if_valid, r_if_adel;
    logic [XLEN-1:0] r_if_instr, r_if_pc, r_if_pc_add_4;
    logic            r_sk_valid;
    logic [XLEN-1:0] r_sk_instr, r_sk_pc;

    logic w_consume, w_free, w_misalign;
    logic w_issue, w_rsp_to_slot, w_rsp_to_skid, w_skid_to_slot, w_pc_inc;

    assign w_consume  = r_if_valid && !bus.id_stall;
    assign w_free     = !r_if_valid || w_consume;
    assign w_misalign = (bus.redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_ISSUE;
        else        r_state <= w_next;
    end

    // Redirect outranks every other event, including a same-cycle response or stall.
    always_comb begin
        w_next         = r_state;
        w_issue        = 1'b0;
        w_rsp_to_slot  = 1'b0;
        w_rsp_to_skid  = 1'b0;
        w_skid_to_slot = 1'b0;
        w_pc_inc       = 1'b0;
        if (bus.redirect_valid) begin
            if (w_misalign)                                w_next = ST_HALT;
            else if (r_state == ST_WAIT && !bus.im_rvalid) w_next = ST_DROP;
            else                                           w_next = ST_ISSUE;
        end else begin
            case (r_state)
                ST_ISSUE: begin
                    w_issue = 1'b1;
                    w_next  = ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.im_rvalid) begin
                        w_pc_inc = 1'b1;
                        if (w_free) begin
                            w_rsp_to_slot = 1'b1;
                            w_next        = ST_ISSUE;
                        end else begin
                            w_rsp_to_skid = 1'b1;
                            w_next        = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_consume && r_sk_valid) begin
                        w_skid_to_slot = 1'b1;
                        w_next         = ST_ISSUE;
                    end
                end
                ST_DROP: begin
                    if (bus.im_rvalid) w_next = ST_ISSUE;
                end
                ST_HALT: w_next = ST_HALT;
                default: w_next = ST_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_im_req      <= 1'b0;
            r_im_addr     <= '0;
            r_if_valid    <= 1'b0;
            r_if_adel     <= 1'b0;
            r_if_instr    <= '0;
            r_if_pc       <= '0;
            r_if_pc_add_4 <= '0;
            r_sk_valid    <= 1'b0;
            r_sk_instr    <= '0;
            r_sk_pc       <= '0;
        end else begin
            r_im_req <= w_issue;
            if (w_issue) r_im_addr <= r_pc;

            if (bus.redirect_valid) r_pc <= bus.redirect_pc;
            else if (w_pc_inc)      r_pc <= pc_add4(r_pc);

            // A misaligned target becomes an address-error marker in the slot instead of a fetch.
            if (bus.redirect_valid) begin
                r_if_valid <= w_misalign;
                r_if_adel  <= w_misalign;
                if (w_misalign) begin
                    r_if_instr    <= '0;
                    r_if_pc       <= bus.redirect_pc;
                    r_if_pc_add_4 <= pc_add4(bus.redirect_pc);
                end
            end else if (w_rsp_to_slot) begin
                r_if_valid    <= 1'b1;
                r_if_adel     <= 1'b0;
                r_if_instr    <= bus.im_rdata;
                r_if_pc       <= r_pc;
                r_if_pc_add_4 <= pc_add4(r_pc);
            end else if (w_skid_to_slot) begin
                r_if_valid    <= 1'b1;
                r_if_adel     <= 1'b0;
                r_if_instr    <= r_sk_instr;
                r_if_pc       <= r_sk_pc;
                r_if_pc_add_4 <= pc_add4(r_sk_pc);
            end else if (w_consume) begin
                r_if_valid <= 1'b0;
                r_if_adel  <= 1'b0;
            end

            if (bus.redirect_valid || w_skid_to_slot) begin
                r_sk_valid <= 1'b0;
            end else if (w_rsp_to_skid) begin
                r_sk_valid <= 1'b1;
                r_sk_instr <= bus.im_rdata;
                r_sk_pc    <= r_pc;
            end
        end
    end

    assign bus.im_req      = r_im_req;
    assign bus.im_addr     = r_im_addr;
    assign bus.if_valid    = r_if_valid;
    assign bus.if_instr    = r_if_instr;
    assign bus.if_pc       = r_if_pc;
    assign bus.if_pc_add_4 = r_if_pc_add_4;
    assign bus.if_adel     = r_if_adel;

    // A response is only legal while a request is outstanding (live or stale).
    a_rvalid_protocol: assert property (@(posedge clk) disable iff (!rst_n)
        bus.im_rvalid |-> (r_state == ST_WAIT || r_state == ST_DROP));

endmodule
